// File: rtl/fpu_arbiter_pkg.sv
// FPU op codes shared with the FPU, plus the sequencer state encoding.
`ifndef FPU_DEFINES_SV
`define FPU_DEFINES_SV
`define FPU_ADD  2'd0
`define FPU_SUB  2'd1
`define FPU_MUL  2'd2
`define FPU_SQRT 2'd3
`endif

package fpu_arbiter_pkg;

    localparam logic [1:0] FPU_OP_ADD  = `FPU_ADD;
    localparam logic [1:0] FPU_OP_SUB  = `FPU_SUB;
    localparam logic [1:0] FPU_OP_MUL  = `FPU_MUL;
    localparam logic [1:0] FPU_OP_SQRT = `FPU_SQRT;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_EXEC_ENC  = 2'd1;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_EXEC  = ST_EXEC_ENC,
        ST_DRAIN = ST_DRAIN_ENC
    } state_t;

    // MUL/SQRT ready may still be left over from the previous op on the first cycle.
    function automatic logic first_cycle_ready_ok(input logic [1:0] op);
        return (op == FPU_OP_ADD) || (op == FPU_OP_SUB);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant with a registered priority pointer.
// Latency: combinational grant; pointer updates on the accepting edge.
// Backpressure: grant is zero whenever enable is low.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       update,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Pointer moves to the port that did not win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (update) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Sequences two clients' ops onto the shared FPU with round-robin arbitration.
// Latency: accept edge + FPU cycles (first MUL/SQRT ready ignored) + 1 DRAIN cycle carrying done.
// Backpressure: rX_ready only in IDLE for the granted port; done/error pulses are never stalled.
module fpu_arbiter
    import fpu_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid,
    input  logic             r1_valid,
    output logic             r0_ready,
    output logic             r1_ready,
    input  logic [1:0]       r0_operation,
    input  logic [1:0]       r1_operation,
    input  logic [WIDTH-1:0] r0_operand_1,
    input  logic [WIDTH-1:0] r0_operand_2,
    input  logic [WIDTH-1:0] r1_operand_1,
    input  logic [WIDTH-1:0] r1_operand_2,
    output logic             r0_done,
    output logic             r1_done,
    output logic             r0_error,
    output logic             r1_error,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       fpu_operation,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic            owner;
    logic [CW-1:0]   cnt;
    logic            err;
    logic [1:0]      req;
    logic [1:0]      grant;
    logic            arb_en;
    logic            accept;
    logic            honoured;
    logic            finish;

    assign req    = {r1_valid, r0_valid};
    assign arb_en = (state == ST_IDLE) && reset;
    assign accept = |grant;

    rr_arbiter_2 u_rr (
        .clk    (clk),
        .rst_n  (reset),
        .req    (req),
        .enable (arb_en),
        .update (accept),
        .grant  (grant)
    );

    assign honoured = fpu_ready && ((cnt != '0) || first_cycle_ready_ok(fpu_operation));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (honoured || (cnt == CNT_LAST)) begin
                    state_nxt = ST_DRAIN;
                    finish    = 1'b1;
                end
            end
            ST_DRAIN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Drive registers fall back to ADD/0 on leaving EXEC so the FPU stage machines rewind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner         <= 1'b0;
            cnt           <= '0;
            err           <= 1'b0;
            result        <= '0;
            fpu_operation <= FPU_OP_ADD;
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
        end else if ((state == ST_IDLE) && accept) begin
            owner         <= grant[1];
            cnt           <= '0;
            fpu_operation <= grant[1] ? r1_operation : r0_operation;
            fpu_operand_1 <= grant[1] ? r1_operand_1 : r0_operand_1;
            fpu_operand_2 <= grant[1] ? r1_operand_2 : r0_operand_2;
        end else if (state == ST_EXEC) begin
            cnt <= cnt + CW'(1);
            if (finish) begin
                result        <= honoured ? fpu_result : '0;
                err           <= !honoured;
                fpu_operation <= FPU_OP_ADD;
                fpu_operand_1 <= '0;
                fpu_operand_2 <= '0;
            end
        end
    end

    assign r0_ready = grant[0];
    assign r1_ready = grant[1];
    assign r0_done  = (state == ST_DRAIN) && !owner;
    assign r1_done  = (state == ST_DRAIN) && owner;
    assign r0_error = r0_done && err;
    assign r1_error = r1_done && err;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a behavioural fixed-point FPU (FBITS=10, 3-cycle MUL/SQRT).
module tb_fpu_arbiter;
    import fpu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [1:0]  r0_operation, r1_operation;
    logic [31:0] r0_operand_1, r0_operand_2, r1_operand_1, r1_operand_2;
    logic        r0_done, r1_done, r0_error, r1_error;
    logic [31:0] result;
    logic [1:0]  fpu_operation;
    logic [31:0] fpu_operand_1, fpu_operand_2, fpu_result;
    logic        fpu_ready;

    int mode;  // 0: ready stuck 1, 1: ready stuck 0, 2: behavioural FPU
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_arbiter #(.WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_operation(r0_operation), .r1_operation(r1_operation),
        .r0_operand_1(r0_operand_1), .r0_operand_2(r0_operand_2),
        .r1_operand_1(r1_operand_1), .r1_operand_2(r1_operand_2),
        .r0_done(r0_done), .r1_done(r1_done),
        .r0_error(r0_error), .r1_error(r1_error),
        .result(result),
        .fpu_operation(fpu_operation),
        .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
        .fpu_result(fpu_result), .fpu_ready(fpu_ready)
    );

    function automatic logic [31:0] isqrt(input logic [63:0] x);
        logic [63:0] r, t;
        r = 64'd0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return r[31:0];
    endfunction

    logic [63:0] prod;
    always_comb begin
        prod = 64'(fpu_operand_1) * 64'(fpu_operand_2);
        fpu_result = fpu_operand_1 + fpu_operand_2;
        case (fpu_operation)
            FPU_OP_SUB:  fpu_result = fpu_operand_1 - fpu_operand_2;
            FPU_OP_MUL:  fpu_result = prod[41:10];
            FPU_OP_SQRT: fpu_result = isqrt({22'd0, fpu_operand_1, 10'd0});
            default:     fpu_result = fpu_operand_1 + fpu_operand_2;
        endcase
    end

    // Registered ready: stays high through ADD/SUB, so it is stale on the first MUL/SQRT cycle.
    int   m_cnt;
    logic m_rdy;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt <= 0;
            m_rdy <= 1'b1;
        end else if (fpu_operation == FPU_OP_ADD || fpu_operation == FPU_OP_SUB) begin
            m_cnt <= 0;
            m_rdy <= 1'b1;
        end else begin
            if (m_cnt < 3) m_cnt <= m_cnt + 1;
            m_rdy <= (m_cnt + 1 >= 3);
        end
    end
    assign fpu_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : m_rdy;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic rdy_of(input int p);
        return (p == 0) ? r0_ready : r1_ready;
    endfunction

    task automatic set_req(input int p, input logic v, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            r0_valid = v; r0_operation = op; r0_operand_1 = a; r0_operand_2 = b;
        end else begin
            r1_valid = v; r1_operation = op; r1_operand_1 = a; r1_operand_2 = b;
        end
    endtask

    // Present a request, wait for its grant, pass the accept edge, then drop valid.
    task automatic issue(input int p, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string nm);
        int n;
        set_req(p, 1'b1, op, a, b);
        n = 0;
        #1;
        while (!rdy_of(p) && n < 50) begin
            step();
            n++;
        end
        check({nm, " grant"}, 32'(rdy_of(p)), 32'd1);
        step();
        set_req(p, 1'b0, op, a, b);
        #1;
        check({nm, " drive op"}, 32'(fpu_operation), 32'(op));
        check({nm, " drive a"}, fpu_operand_1, a);
        check({nm, " drive b"}, fpu_operand_2, b);
    endtask

    task automatic do_op(input int p, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ee,
                         input int en, input string nm);
        int n;
        issue(p, op, a, b, nm);
        n = 1;
        while (!(r0_done || r1_done) && n < 40) begin
            step();
            n++;
        end
        check({nm, " latency"}, 32'(n), 32'(en));
        check({nm, " own done"}, 32'(p == 0 ? r0_done : r1_done), 32'd1);
        check({nm, " other done"}, 32'(p == 0 ? r1_done : r0_done), 32'd0);
        check({nm, " error"}, 32'(p == 0 ? r0_error : r1_error), 32'(ee));
        check({nm, " result"}, result, er);
        check({nm, " drain op"}, 32'(fpu_operation), 32'(FPU_OP_ADD));
        check({nm, " drain operands"}, fpu_operand_1 | fpu_operand_2, 32'd0);
        step();
        check({nm, " done one cycle"}, 32'(r0_done | r1_done), 32'd0);
    endtask

    typedef struct {
        int          mode;
        int          port;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen, dones;
        int grants[$];
        int g0, g1, g2;

        vecs[0] = '{0, 0, FPU_OP_ADD,  32'h600,  32'h800, 32'hE00, 1'b0, 2, "add r0"};
        vecs[1] = '{0, 1, FPU_OP_SUB,  32'h800,  32'h600, 32'h200, 1'b0, 2, "sub r1"};
        vecs[2] = '{0, 1, FPU_OP_SQRT, 32'h1000, 32'h0,   32'h800, 1'b0, 3, "sqrt stale ready"};
        vecs[3] = '{1, 0, FPU_OP_MUL,  32'h600,  32'h800, 32'h0,   1'b1, 9, "timeout"};
        vecs[4] = '{0, 0, FPU_OP_ADD,  32'h100,  32'h200, 32'h300, 1'b0, 2, "after timeout"};
        vecs[5] = '{2, 0, FPU_OP_MUL,  32'h600,  32'h800, 32'hC00, 1'b0, 5, "mul model"};
        vecs[6] = '{2, 1, FPU_OP_SQRT, 32'h1000, 32'h0,   32'h800, 1'b0, 5, "sqrt model"};
        vecs[7] = '{2, 1, FPU_OP_ADD,  32'h100,  32'h100, 32'h200, 1'b0, 2, "add model"};

        mode = 0;
        reset = 1'b0;
        set_req(0, 1'b1, FPU_OP_MUL, 32'h5, 32'h6);
        set_req(1, 1'b1, FPU_OP_SUB, 32'h7, 32'h8);
        #1;
        check("reset r0_ready", 32'(r0_ready), 32'd0);
        check("reset r1_ready", 32'(r1_ready), 32'd0);
        check("reset done", 32'({r0_done, r1_done, r0_error, r1_error}), 32'd0);
        check("reset result", result, 32'd0);
        check("reset fpu op", 32'(fpu_operation), 32'(FPU_OP_ADD));
        check("reset fpu operands", fpu_operand_1 | fpu_operand_2, 32'd0);
        set_req(0, 1'b0, FPU_OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b0, FPU_OP_ADD, 32'd0, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode;
            do_op(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].err, vecs[i].lat, vecs[i].nm);
        end

        // Reset during EXEC of a MUL: everything clears at once and no done appears.
        mode = 2;
        issue(0, FPU_OP_MUL, 32'h600, 32'h800, "rst mul");
        step();
        set_req(0, 1'b1, FPU_OP_MUL, 32'h600, 32'h800);
        set_req(1, 1'b1, FPU_OP_SQRT, 32'h1000, 32'h0);
        reset = 1'b0;
        #1;
        check("mid reset ready", 32'({r0_ready, r1_ready}), 32'd0);
        check("mid reset result", result, 32'd0);
        check("mid reset fpu op", 32'(fpu_operation), 32'(FPU_OP_ADD));
        check("mid reset fpu operands", fpu_operand_1 | fpu_operand_2, 32'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (r0_done || r1_done) seen++;
            step();
        end
        check("mid reset no done", 32'(seen), 32'd0);
        reset = 1'b1;

        // Both ports valid continuously: grants alternate starting at r0.
        dones = 0;
        n = 0;
        while (dones < 3 && n < 200) begin
            #1;
            if (r0_ready && r1_ready) check("fair both ready", 32'd1, 32'd0);
            if (r0_ready) grants.push_back(0);
            else if (r1_ready) grants.push_back(1);
            if (r0_done || r1_done) begin
                dones++;
                check("fair result", result, r0_done ? 32'hC00 : 32'h800);
                check("fair drain op", 32'(fpu_operation), 32'(FPU_OP_ADD));
                check("fair drain operands", fpu_operand_1 | fpu_operand_2, 32'd0);
            end
            step();
            n++;
        end
        set_req(0, 1'b0, FPU_OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b0, FPU_OP_ADD, 32'd0, 32'd0);
        check("fair done count", 32'(dones), 32'd3);
        g0 = grants.size() > 0 ? grants[0] : -1;
        g1 = grants.size() > 1 ? grants[1] : -1;
        g2 = grants.size() > 2 ? grants[2] : -1;
        check("fair grant order", 32'({g0[3:0], g1[3:0], g2[3:0]}), 32'h010);
        step();

        // r0 drops valid while r1 is busy: it is never served.
        issue(1, FPU_OP_MUL, 32'h600, 32'h800, "drop r1");
        set_req(0, 1'b1, FPU_OP_ADD, 32'h100, 32'h100);
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (r0_ready) seen++;
            step();
        end
        set_req(0, 1'b0, FPU_OP_ADD, 32'h100, 32'h100);
        n = 0;
        while (!r1_done && n < 40) begin
            if (r0_done) seen++;
            step();
            n++;
        end
        check("drop r1 result", result, 32'hC00);
        for (int i = 0; i < 8; i++) begin
            if (r0_done || r0_ready) seen++;
            step();
        end
        check("drop r0 never served", 32'(seen), 32'd0);

        // Payload changes while waiting: value present at the accept edge is used.
        issue(1, FPU_OP_MUL, 32'h600, 32'h800, "chg r1");
        set_req(0, 1'b1, FPU_OP_ADD, 32'h100, 32'h100);
        step();
        set_req(0, 1'b1, FPU_OP_ADD, 32'h300, 32'h400);
        step();
        do_op(0, FPU_OP_ADD, 32'h300, 32'h400, 32'h700, 1'b0, 2, "payload change");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Sequencer and two-port round-robin arbiter for the shared fixed-point unit (FPU: add/sub/mul/sqrt, variable latency, level `ready`). It accepts operation requests from two clients (e.g. integer pipeline and load/store microcode) and drives the FPU with stable operands and operation code until completion. It returns a one-cycle result pulse to the issuing client, with a timeout error if the FPU never signals ready. It sits between the clients and the FPU and is the only driver of the FPU's inputs.

## Interface
- `WIDTH`, 32: operand/result width (FPU width; FBITS handled inside the FPU).
- `TIMEOUT`, 64: maximum EXEC cycles before aborting; ≥ 2.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `r0_valid`, `r1_valid` in 1: request pending.
- `r0_ready`, `r1_ready` out 1: request accepted this cycle. Transfer = valid & ready at clk edge.
- `r0_operation`, `r1_operation` in 2: FPU op code (`FPU_ADD`/`SUB`/`MUL`/`SQRT` from shared defines).
- `r0_operand_1`, `r0_operand_2`, `r1_operand_1`, `r1_operand_2` in WIDTH: operands.
- `r0_done`, `r1_done` out 1: one-cycle completion pulse; no backpressure.
- `r0_error`, `r1_error` out 1: valid with done; 1 = timeout.
- `result` out WIDTH: shared result register, valid while either done is high.
- `fpu_operation` out 2, `fpu_operand_1` out WIDTH, `fpu_operand_2` out WIDTH: registered drive to the FPU.
- `fpu_result` in WIDTH, `fpu_ready` in 1: FPU outputs.

## Operation
- States: IDLE, EXEC, DRAIN. Reset → IDLE.
- IDLE: combinational grant. If exactly one valid, that port wins. If both are valid, the port indicated by priority pointer `ptr` wins. `rX_ready` is high only for the granted port, and only in IDLE. On transfer, latch op/operands into the FPU drive registers, record `owner`, flip `ptr` to the other port, clear the cycle counter, and go to EXEC.
- EXEC: the FPU inputs are held constant. The counter increments every cycle.
  - `fpu_ready` is ignored in the first EXEC cycle for MUL/SQRT, because the FPU's ready for those ops can be stale from a previous op. It is honoured in the first cycle for ADD/SUB.
  - On an honoured `fpu_ready`=1: capture `fpu_result` into `result`, set `error`=0, go to DRAIN.
  - When the counter reaches TIMEOUT-1 without ready: `result`=0, `error`=1, go to DRAIN.
- DRAIN (exactly 1 cycle):
  - `rOwner_done`=1 and `rOwner_error` = captured error.
  - `fpu_operation` = `FPU_ADD` and operands = 0. This forces the FPU's MUL/SQRT stage machines back to stage 0 before the next op.
  - Then go to IDLE. No grant is made in DRAIN.
- Requests with valid dropped before ready are simply not serviced; clients must hold valid and payload until ready.
- Reset values: state IDLE, `ptr`=0, `owner`=0, counter 0, `fpu_operation`=`FPU_ADD`, `fpu_operand_*`=0, `result`=0, all done/error/ready=0. `rX_ready` is forced to 0 while reset is asserted.
- Reset mid-EXEC: abandon the op immediately; no done pulse is ever produced for it.

## Timing
- Accept at edge E0. FPU is driven from cycle E0+1.
- ADD/SUB with a combinational FPU ready: capture at E1, done high in cycle E1→E2, IDLE at E2. Next accept is possible at edge E3, giving 3 cycles per op.
- MUL/SQRT: done is high the cycle after the first honoured ready edge. Total latency = FPU latency + 1 (DRAIN) + 1 (accept).
- Timeout: done and error are high in the cycle after EXEC cycle number TIMEOUT.
- Fairness: with both ports valid continuously, grants alternate 0,1,0,1… starting from port 0 after reset.

## Structure
- FPU op code defines (`FPU_ADD`, `FPU_SUB`, `FPU_MUL`, `FPU_SQRT`) stay in the shared defines file.
- The state encoding (IDLE/EXEC/DRAIN) belongs in the shared package as a localparam set.
- One natural sub-module, `rr_arbiter_2`: combinational 2-way grant plus registered priority pointer, with an update-on-accept input.
- The counter width is clog2(TIMEOUT).

## Test plan
- ADD on r0, operands 0x600 and 0x800 (1.5 + 2.0, FBITS=10), stub FPU with ready=1 → r0_ready at E0, `result`=0xE00, r0_done for exactly 1 cycle at E2, r1_done stays 0.
- Both ports valid continuously, r0 MUL 0x600×0x800 and r1 SQRT 0x1000 on the real FPU:
  - grants alternate r0, r1, r0.
  - r0 `result`=0xC00; r1 `result`=0x800.
  - Every DRAIN cycle shows `fpu_operation`=`FPU_ADD` with operands 0.
- Stub FPU holds ready=1 permanently, r1 issues SQRT → ready ignored in the first EXEC cycle, so the result is captured at the second EXEC edge, not the first.
- Stub FPU with ready stuck at 0, TIMEOUT=8 → r0_done and r0_error both =1 in the cycle after 8 EXEC cycles, `result`=0, then IDLE accepts a new request.
- Reset (low) asserted during EXEC of a MUL → all outputs return to their reset values asynchronously, no done pulse appears, and after release the first grant goes to r0.
- r0 valid drops before grant while r1 is busy → r0 never receives done. Payload changes while r0 is valid with ready low → the value latched is the one present at the accept edge.
